blake2_block_packer: RTL and testbench
======================================

# blake2_block_packer

Upstream feeder for the `blake2` compression core. It accepts a message as a stream of W-bit little-endian words with a valid/ready handshake and assembles them into 16-word blocks. The final block is zero-padded. The block packer tracks the running byte offset `t` and marks the final block. It issues one block at a time to the core as a single-cycle strobe and waits for the core's done pulse before issuing the next block, while the following block is filled in parallel.

## Interface
Parameters:
- `W`, 64, word width in bits (64 = BLAKE2b, 32 = BLAKE2s)
- `NW`, 16, words per block
- `BW`, 4, width of `s_bytes_i`; must equal clog2(W/8)+1

Ports:
- `clk` input 1: clock
- `nreset` input 1: reset, synchronous, active-low
- `s_valid_i` input 1: input word valid
- `s_ready_o` output 1: input word accepted when `s_valid_i & s_ready_o`
- `s_data_i` input W: message word; byte k is at bits [8k+7:8k]
- `s_last_i` input 1: this word is the last word of the message
- `s_bytes_i` input BW: number of valid bytes in the word, 0..W/8; only meaningful when `s_last_i`=1, and taken as W/8 otherwise
- `core_done_i` input 1: core finished the issued block (the core's `valid_o`)
- `blk_valid_o` output 1: one-cycle block strobe (drives the core's `valid_i`)
- `blk_data_o` output W*NW: block; word i is at bits [W*i+W-1:W*i]
- `blk_t_o` output 2W: total message bytes up to and including this block
- `blk_last_o` output 1: final-block flag
- `err_o` output 1: sticky protocol error (see Configuration)

## Operation
- Registers:
  - block buffer
  - 4-bit word index `idx`
  - block byte count `bc` (0..W/8*NW)
  - message offset `t_q` (2W bits)
  - `busy_q`
  - `final_q`
  - 2-bit state
- Byte masking: bytes at positions ≥ `s_bytes_i` of the last word are written as zero.
- State FILL: `s_ready_o`=1.
  - An accepted word is written to buffer[`idx`]; `bc += bytes`.
  - `s_last_i`=1: `final_q`=1, go to PEND.
  - `idx`==NW-1 and not last: go to HOLD.
  - Otherwise `idx`++.
- State HOLD: the buffer is full and it is not yet known whether this is the final block. `s_ready_o` = `s_last_i & (s_bytes_i==0)`, a combinational decision.
  - If `s_valid_i` with last and 0 bytes: consume that word, `final_q`=1, go to PEND.
  - If `s_valid_i` with any other word: do not consume it, `final_q`=0, go to PEND.
  - If no `s_valid_i`: stay in HOLD.
- State PEND: `s_ready_o`=0. `blk_valid_o` = `~busy_q`.
  - On issue: `t_q += bc`, `blk_t_o` presents `t_q+bc`, `busy_q`=1.
  - Then clear the buffer, set `idx`=0 and `bc`=0, and go to FILL.
  - If `final_q`, also clear `t_q` to 0 after the issue.
- `core_done_i` clears `busy_q`. It is ignored when `busy_q`=0.
- `blk_data_o`, `blk_t_o` and `blk_last_o` are valid only while `blk_valid_o`=1. They are driven from registers, with no input-to-output combinational path.
- Empty message: last word with 0 bytes accepted in FILL at `idx`=0 produces an all-zero block with t=0 and last=1.
- `t_q` wraps modulo 2^(2W).

## Timing
- Reset values:
  - `blk_valid_o`=0, `blk_last_o`=0, `blk_t_o`=0, `blk_data_o`=0, `err_o`=0
  - state FILL, `busy_q`=0
  - `s_ready_o`=0 while `nreset` is low, and 1 from the first cycle after reset.
- Latency: if the completing word is accepted in cycle N and `busy_q`=0, `blk_valid_o`=1 in cycle N+1, for exactly one cycle.
- Issue to core: the next issue is at the earliest one cycle after `core_done_i`. Filling of the next block proceeds during the core's 12 busy cycles.
- HOLD resolves in the same cycle that `s_valid_i` is seen. PEND is entered on the next edge.
- Reset mid-block: the partial block and `t_q` are discarded, and `busy_q` is cleared.

## Configuration
- `BLAKE2_PACKER_ERR_EN`: compiles in protocol checking.
  - `err_o` is set sticky (until reset) on any accepted word with `s_bytes_i` > W/8.
  - `err_o` is also set on any accepted word with `s_last_i`=1, `s_bytes_i`=0 and `idx`≠0, except when that word is consumed in HOLD.
  - Checking does not alter data flow.
- Without the macro: `err_o` is tied to 0 and no checking logic is built.

## Test plan
- "abc": one word 0x636261, bytes=3, last → next cycle `blk_valid_o`=1, word0=0x0000000000636261, words 1-15 = 0, t=3, last=1.
- Empty message: last, bytes=0 → all-zero block, t=0, last=1, one strobe.
- 128 bytes: 16 full words → HOLD with `s_ready_o`=0; then last with bytes=0 → word consumed, one block with t=128, last=1.
- 136 bytes: 16 words plus one 8-byte last word.
  - First block: t=128, last=0; the 17th word is held off until the issue.
  - After `core_done_i`, second block: word0 = 17th word, t=136, last=1.
- Backpressure: hold `core_done_i` low for 20 cycles after the first issue while a second block completes.
  - `blk_valid_o` stays 0.
  - It rises exactly one cycle after `core_done_i`.
- Reset after 5 words, then "abc" → a single block identical to the first scenario. With the macro enabled, bytes=9 sets `err_o`=1.

Source files
------------

// File: rtl/blake2_block_packer.sv
// blake2_block_packer
// Feeder for the blake2 compression core. Collects a little-endian word stream
// (valid/ready) into NW-word blocks and zero-pads the final block. It also keeps
// the running byte offset t and the final-block flag. A block goes to the core as
// a one-cycle strobe. The next block cannot issue until the core reports done, but
// it can be filled while the core is still busy.
//
// Optional build macro:
//   BLAKE2_PACKER_ERR_EN - compiles in protocol checking that drives a sticky err_o.
//                          When it is undefined, err_o is tied low.
module blake2_block_packer #(
    parameter int W  = 64,
    parameter int NW = 16,
    parameter int BW = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [W-1:0]      s_data_i,
    input  logic              s_last_i,
    input  logic [BW-1:0]     s_bytes_i,
    input  logic              core_done_i,
    output logic              blk_valid_o,
    output logic [W*NW-1:0]   blk_data_o,
    output logic [2*W-1:0]    blk_t_o,
    output logic              blk_last_o,
    output logic              err_o
);

    localparam int NB  = W / 8;                // bytes per word
    localparam int IW  = $clog2(NW);           // word index width
    localparam int BCW = $clog2(NB * NW + 1);  // block byte count width

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IW-1:0]    idx_reg;
    logic [BCW-1:0]   bc_reg;
    logic [2*W-1:0]   t_reg;
    logic             busy_reg;
    logic             final_reg;
    logic [W-1:0]     buf_reg [NW];

    logic [BW-1:0]    eff_bytes;
    logic [W-1:0]     masked_word;
    logic             fill_wr;
    logic             hold_empty_last;
    logic             issue;

    // Valid byte count of the incoming word. Words that are not last are always
    // full. An oversize count on a last word is clamped so bc never overruns.
    always_comb begin
        eff_bytes = BW'(NB);
        if (s_last_i && (s_bytes_i <= BW'(NB)))
            eff_bytes = s_bytes_i;
    end

    // Zero every byte at or beyond the valid count, so the block tail is padded.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_mask
            assign masked_word[8*gi +: 8] = (BW'(gi) < eff_bytes) ? s_data_i[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // HOLD can only swallow an empty last word. Any other word is left waiting
    // for the next block, and the current block is marked non-final.
    assign hold_empty_last = s_last_i && (s_bytes_i == '0);
    assign s_ready_o       = nreset && ((state_reg == ST_FILL) ||
                                        ((state_reg == ST_HOLD) && hold_empty_last));
    assign fill_wr         = (state_reg == ST_FILL) && s_valid_i;
    assign issue           = (state_reg == ST_PEND) && !busy_reg;

    // The block outputs depend only on registers, so there is no path from the
    // input ports.
    assign blk_valid_o = issue;
    assign blk_t_o     = t_reg + {{(2*W-BCW){1'b0}}, bc_reg};
    assign blk_last_o  = final_reg;

    // Block buffer. Each word is loaded at its index and cleared when the block
    // issues, so the next block starts zero-padded.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (!nreset)
                    buf_reg[gi] <= '0;
                else if (issue)
                    buf_reg[gi] <= '0;
                else if (fill_wr && (idx_reg == IW'(gi)))
                    buf_reg[gi] <= masked_word;
            end
            assign blk_data_o[W*gi +: W] = buf_reg[gi];
        end
    endgenerate

    // Control FSM: fill, resolve a full block, issue, and track the core busy flag.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg <= ST_FILL;
            idx_reg   <= '0;
            bc_reg    <= '0;
            t_reg     <= '0;
            busy_reg  <= 1'b0;
            final_reg <= 1'b0;
        end else begin
            // done is only meaningful while a block is out; issuing sets busy.
            if (issue)
                busy_reg <= 1'b1;
            else if (core_done_i)
                busy_reg <= 1'b0;

            case (state_reg)
                ST_FILL: begin
                    if (s_valid_i) begin
                        bc_reg <= bc_reg + BCW'(eff_bytes);
                        if (s_last_i) begin
                            final_reg <= 1'b1;
                            state_reg <= ST_PEND;
                        end else if (idx_reg == IW'(NW - 1)) begin
                            state_reg <= ST_HOLD;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (s_valid_i) begin
                        final_reg <= hold_empty_last;
                        state_reg <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (issue) begin
                        // Offset restarts after the final block of a message.
                        t_reg     <= final_reg ? '0 : (t_reg + {{(2*W-BCW){1'b0}}, bc_reg});
                        idx_reg   <= '0;
                        bc_reg    <= '0;
                        final_reg <= 1'b0;
                        state_reg <= ST_FILL;
                    end
                end
                default: state_reg <= ST_FILL;
            endcase
        end
    end

`ifdef BLAKE2_PACKER_ERR_EN
    logic err_reg;
    logic word_taken;
    logic bad_bytes;
    logic bad_empty;

    assign word_taken = s_valid_i && s_ready_o;
    assign bad_bytes  = s_bytes_i > BW'(NB);
    // An empty last word is legal only at the start of a block. The copy
    // consumed in HOLD is the expected way to close an exact-multiple message.
    assign bad_empty  = (state_reg == ST_FILL) && s_last_i &&
                        (s_bytes_i == '0) && (idx_reg != '0);

    // Sticky protocol error flag. It is cleared only by reset.
    always_ff @(posedge clk) begin
        if (!nreset)
            err_reg <= 1'b0;
        else if (word_taken && (bad_bytes || bad_empty))
            err_reg <= 1'b1;
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blake2_block_packer.sv
// Testbench for blake2_block_packer (W=64, NW=16). Directed messages are split into
// words with junk in the unused bytes. A message-level model predicts the blocks,
// and a negedge monitor acts as the core and checks every strobe.
module tb_blake2_block_packer;

    localparam int W  = 64;
    localparam int NW = 16;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [W-1:0]      s_data_i = '0;
    logic              s_last_i = 1'b0;
    logic [BW-1:0]     s_bytes_i = '0;
    logic              core_done_i = 1'b0;
    logic              blk_valid_o;
    logic [W*NW-1:0]   blk_data_o;
    logic [2*W-1:0]    blk_t_o;
    logic              blk_last_o;
    logic              err_o;

    blake2_block_packer #(.W(W), .NW(NW), .BW(BW)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .s_bytes_i   (s_bytes_i),
        .core_done_i (core_done_i),
        .blk_valid_o (blk_valid_o),
        .blk_data_o  (blk_data_o),
        .blk_t_o     (blk_t_o),
        .blk_last_o  (blk_last_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]        msg [$];
    logic [W*NW-1:0]   exp_data_q [$];
    logic [2*W-1:0]    exp_t_q [$];
    logic              exp_last_q [$];

    bit  core_busy_m = 1'b0;
    bit  prev_valid = 1'b0;
    bit  expect_rise = 1'b0;
    bit  done_just = 1'b0;
    int  done_delay = 12;
    int  busy_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a message of L bytes becomes max(1, ceil(L/128)) blocks of 128 bytes,
    // zero past L. t is the number of message bytes covered so far, and the last
    // block is flagged.
    task automatic model_message(input int len);
        int nblk;
        logic [W*NW-1:0] d;
        logic [2*W-1:0]  t;
        nblk = (len == 0) ? 1 : (len + 127) / 128;
        for (int b = 0; b < nblk; b++) begin
            d = '0;
            for (int i = 0; i < 128; i++)
                if (128*b + i < len) d[8*i +: 8] = msg[128*b + i];
            t = ((128*(b+1)) < len) ? 128'(128*(b+1)) : 128'(len);
            exp_data_q.push_back(d);
            exp_t_q.push_back(t);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    task automatic fill_msg(input int len, input int seed);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'(i * 7 + seed));
    endtask

    // Word j of the current message. Bytes past the end carry junk that the DUT must mask.
    function automatic logic [63:0] word_of(input int j, input int len);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++)
            d[8*k +: 8] = (8*j + k < len) ? msg[8*j + k] : 8'hA5;
        return d;
    endfunction

    // Present one word at a negedge and hold it until it is accepted. Return at the
    // negedge after the accepting edge.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [BW-1:0] nb);
        bit r;
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        s_bytes_i = nb;
        while (!ok && waited < 500) begin
            #1 r = s_ready_o;
            @(posedge clk);
            if (r) ok = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        if (!ok) chk("accept_timeout", 128'(waited), 128'(0));
        @(negedge clk);
        s_valid_i = 1'b0;
    endtask

    task automatic send_message(input int len, input bit extra_empty);
        int nwords;
        bit last;
        nwords = (len + 7) / 8;
        for (int j = 0; j < nwords; j++) begin
            last = (j == nwords - 1) && !extra_empty;
            send_word(word_of(j, len), last, last ? BW'(len - 8*j) : BW'(8));
        end
        if (len == 0 || extra_empty) send_word(64'hDEADBEEFDEADBEEF, 1'b1, '0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((core_busy_m || exp_t_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 128'(n >= 2000), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    // Core stand-in and strobe checker: it runs on every negedge after reset.
    always @(negedge clk) begin
        if (!nreset) begin
            core_busy_m = 1'b0;
            core_done_i = 1'b0;
            prev_valid  = 1'b0;
        end else begin
            done_just = 1'b0;
            if (core_done_i) begin
                core_done_i = 1'b0;
                core_busy_m = 1'b0;
                done_just   = 1'b1;
            end
            if (expect_rise && done_just) begin
                chk("rise_after_done", 128'(blk_valid_o), 128'(1));
                expect_rise = 1'b0;
            end
            if (blk_valid_o) begin
                chk("strobe_while_core_busy", 128'(core_busy_m), 128'(0));
                chk("strobe_width", 128'(prev_valid), 128'(0));
                chk("ready_during_issue", 128'(s_ready_o), 128'(0));
                if (exp_t_q.size() == 0) begin
                    chk("unexpected_block_t", blk_t_o, 128'hFFFF_FFFF);
                end else begin
                    for (int w = 0; w < NW; w++)
                        chk($sformatf("blk_word%0d", w), 128'(blk_data_o[64*w +: 64]),
                            128'(exp_data_q[0][64*w +: 64]));
                    chk("blk_t", blk_t_o, exp_t_q[0]);
                    chk("blk_last", 128'(blk_last_o), 128'(exp_last_q[0]));
                    void'(exp_data_q.pop_front());
                    void'(exp_t_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                core_busy_m = 1'b1;
                busy_cnt    = done_delay;
            end else if (core_busy_m) begin
                if (busy_cnt <= 1) core_done_i = 1'b1;
                else busy_cnt--;
            end
            prev_valid = blk_valid_o;
        end
    end

    task automatic do_abc();
        fill_msg(0, 0);
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        model_message(3);
        send_message(3, 1'b0);
        chk("abc_latency", 128'(blk_valid_o), 128'(1));
        chk("abc_word0", 128'(blk_data_o[63:0]), 128'h636261);
        chk("abc_upper_zero", 128'(|blk_data_o[W*NW-1:64]), 128'(0));
        chk("abc_t", blk_t_o, 128'd3);
        chk("abc_last", 128'(blk_last_o), 128'(1));
        wait_idle();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(s_ready_o), 128'(0));
        chk("rst_valid", 128'(blk_valid_o), 128'(0));
        chk("rst_t", blk_t_o, 128'(0));
        chk("rst_data", 128'(|blk_data_o), 128'(0));
        chk("rst_last", 128'(blk_last_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        nreset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'(s_ready_o), 128'(1));

        // "abc"
        do_abc();

        // Empty message
        fill_msg(0, 0);
        model_message(0);
        send_message(0, 1'b0);
        chk("empty_latency", 128'(blk_valid_o), 128'(1));
        chk("empty_data", 128'(|blk_data_o), 128'(0));
        chk("empty_t", blk_t_o, 128'(0));
        chk("empty_last", 128'(blk_last_o), 128'(1));
        wait_idle();

        // 128 bytes: 16 full words, then HOLD, then an empty last word
        fill_msg(128, 3);
        model_message(128);
        for (int j = 0; j < 16; j++) send_word(word_of(j, 128), 1'b0, BW'(8));
        chk("hold_ready", 128'(s_ready_o), 128'(0));
        chk("hold_no_issue", 128'(blk_valid_o), 128'(0));
        @(negedge clk);
        chk("hold_still_ready0", 128'(s_ready_o), 128'(0));
        send_word(64'h0123456789ABCDEF, 1'b1, '0);
        chk("b128_latency", 128'(blk_valid_o), 128'(1));
        chk("b128_t", blk_t_o, 128'd128);
        chk("b128_last", 128'(blk_last_o), 128'(1));
        wait_idle();

        // 136 bytes: two blocks, with the 17th word held off
        fill_msg(136, 11);
        model_message(136);
        send_message(136, 1'b0);
        wait_idle();

        // 300 bytes with a 4-byte tail
        fill_msg(300, 29);
        model_message(300);
        send_message(300, 1'b0);
        wait_idle();

        // Backpressure: the core holds done off for 20 cycles
        done_delay = 20;
        fill_msg(136, 77);
        model_message(136);
        send_message(136, 1'b0);
        chk("bp_core_still_busy", 128'(core_busy_m), 128'(1));
        expect_rise = 1'b1;
        wait_idle();
        chk("bp_rise_seen", 128'(expect_rise), 128'(0));
        done_delay = 12;

        // Reset in the middle of a block, then "abc"
        fill_msg(40, 5);
        for (int j = 0; j < 5; j++) send_word(word_of(j, 40), 1'b0, BW'(8));
        nreset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 128'(s_ready_o), 128'(0));
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 128'(blk_valid_o), 128'(0));
        chk("midrst_data", 128'(|blk_data_o), 128'(0));
        do_abc();

`ifdef BLAKE2_PACKER_ERR_EN
        chk("err_clean", 128'(err_o), 128'(0));
        fill_msg(8, 1);
        model_message(8);
        send_word(word_of(0, 8), 1'b1, BW'(9));
        chk("err_set", 128'(err_o), 128'(1));
        wait_idle();
        chk("err_sticky", 128'(err_o), 128'(1));
`else
        chk("err_tied_low", 128'(err_o), 128'(0));
`endif

        chk("blocks_outstanding", 128'(exp_t_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule
